// File: rtl/hci_lane_seq.sv
// Host control interface for a multi-lane FPU: CMD/STATUS/operand/result banks on the software bus.
// A doorbell sequencer issues the lanes one at a time and raises a maskable interrupt. Define HCI_TIMEOUT_EN to add a per-lane watchdog.
module hci_lane_seq #(
    parameter int NUM_LANES      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] sw_address,
    input  logic        sw_read_en,
    input  logic        sw_write_en,
    input  logic [31:0] sw_datain,
    output logic [31:0] sw_dataout,
    output logic        fpu_rst,
    output logic        fpu_en,
    output logic        fpu_start,
    output logic [31:0] fpu_operand_a,
    output logic [31:0] fpu_operand_b,
    output logic [31:0] fpu_operand_c,
    output logic [1:0]  fpu_format,
    output logic [1:0]  fpu_operation,
    output logic        fpu_fused_m_a,
    input  logic [31:0] fpu_result,
    input  logic [3:0]  fpu_flags,
    input  logic        fpu_ready,
    output logic        irq
);

    if (NUM_LANES < 1 || NUM_LANES > 16) begin : g_bad_lanes
        $error("hci_lane_seq: NUM_LANES must be 1..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("hci_lane_seq: TIMEOUT_CYCLES must be 1..65535");
    end

    localparam int         LW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [3:0] LAST_MAX = 4'(NUM_LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  lane_q, lane_d;
    logic [31:0] cmd_q, cmd_d;
    logic        done_q, done_d;
    logic [3:0]  flg_q, flg_d;
    logic        rst_q;
    logic [31:0] dout_q;
    logic [31:0] opa_q [NUM_LANES];
    logic [31:0] opb_q [NUM_LANES];
    logic [31:0] opc_q [NUM_LANES];
    logic [31:0] out_q [NUM_LANES];

    logic        wr, rd, aligned, busy;
    logic        sel_cmd, sel_sts, sel_opa, sel_opb, sel_opc, sel_out;
    logic [31:0] off_a, off_b, off_c, off_o;
    logic [3:0]  idx;
    logic        idx_ok;
    logic [LW-1:0] lidx, cur;
    logic        soft_rst, doorbell, bank_we;
    logic        job_start, capture, set_done;
    logic        sts_tmo;
    logic [31:0] rdata;

    // Simultaneous read and write strobes are treated as no access at all.
    assign wr      = sw_write_en & ~sw_read_en;
    assign rd      = sw_read_en & ~sw_write_en;
    assign aligned = (sw_address[1:0] == 2'b00);
    assign off_a   = sw_address - 32'h010;
    assign off_b   = sw_address - 32'h050;
    assign off_c   = sw_address - 32'h090;
    assign off_o   = sw_address - 32'h130;
    assign sel_cmd = (sw_address == 32'h000);
    assign sel_sts = (sw_address == 32'h110);
    assign sel_opa = aligned && (off_a < 32'h040);
    assign sel_opb = aligned && (off_b < 32'h040);
    assign sel_opc = aligned && (off_c < 32'h040);
    assign sel_out = aligned && (off_o < 32'h040);

    always_comb begin
        idx = off_o[5:2];
        if (sel_opa)      idx = off_a[5:2];
        else if (sel_opb) idx = off_b[5:2];
        else if (sel_opc) idx = off_c[5:2];
    end

    assign idx_ok   = ({28'd0, idx} < 32'(NUM_LANES));
    assign lidx     = idx[LW-1:0];
    assign cur      = lane_q[LW-1:0];
    assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign soft_rst = wr && sel_cmd && sw_datain[0];
    assign doorbell = wr && sel_cmd && sw_datain[2] && (sw_datain[1] || cmd_q[1]) && !soft_rst;
    assign bank_we  = wr && !busy && idx_ok;

`ifdef HCI_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt_q;
    logic        tmo_q, tmo_d, tmo_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                wd_cnt_q <= '0;
        else if (state_q == S_ISSUE) wd_cnt_q <= '0;
        else if (state_q == S_WAIT)  wd_cnt_q <= wd_cnt_q + 16'd1;
    end

    always_comb begin
        tmo_d = tmo_q;
        if (wr && sel_sts && sw_datain[6]) tmo_d = 1'b0;
        if (job_start)                     tmo_d = 1'b0;
        if (tmo_set)                       tmo_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tmo_q <= 1'b0;
        else          tmo_q <= tmo_d;
    end

    assign sts_tmo = tmo_q;
`else
    assign sts_tmo = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        fpu_start = 1'b0;
        job_start = 1'b0;
        capture   = 1'b0;
        set_done  = 1'b0;
`ifdef HCI_TIMEOUT_EN
        tmo_set   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (doorbell) begin
                    job_start = 1'b1;
                    lane_d    = 4'd0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fpu_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (fpu_ready) begin
                    capture = 1'b1;
                    if (lane_q == cmd_q[19:16]) begin
                        set_done = 1'b1;
                        lane_d   = 4'd0;
                        state_d  = S_DONE;
                    end else begin
                        lane_d  = lane_q + 4'd1;
                        state_d = S_ISSUE;
                    end
                end
`ifdef HCI_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    tmo_set  = 1'b1;
                    set_done = 1'b1;
                    lane_d   = 4'd0;
                    state_d  = S_DONE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        // Soft reset aborts from any state without reporting completion.
        if (soft_rst) begin
            state_d   = S_IDLE;
            lane_d    = 4'd0;
            job_start = 1'b0;
            capture   = 1'b0;
            set_done  = 1'b0;
`ifdef HCI_TIMEOUT_EN
            tmo_set   = 1'b0;
`endif
        end
    end

    always_comb begin
        cmd_d = cmd_q;
        if (wr && sel_cmd) begin
            cmd_d[1]     = sw_datain[1];
            cmd_d[31:20] = sw_datain[31:20];
            if (!busy) begin
                cmd_d[15:3]  = sw_datain[15:3];
                cmd_d[19:16] = (sw_datain[19:16] > LAST_MAX) ? LAST_MAX : sw_datain[19:16];
            end
        end
    end

    // Hardware sets are applied after the W1C clear so they win a collision.
    always_comb begin
        done_d = done_q;
        flg_d  = flg_q;
        if (wr && sel_sts) begin
            done_d = done_q & ~sw_datain[1];
            flg_d  = flg_q & ~sw_datain[5:2];
        end
        if (job_start) begin
            done_d = 1'b0;
            flg_d  = 4'd0;
        end
        if (capture)  flg_d  = flg_d | fpu_flags;
        if (set_done) done_d = 1'b1;
    end

    always_comb begin
        rdata = 32'h0;
        if (sel_cmd)      rdata = {cmd_q[31:3], busy, cmd_q[1:0]};
        else if (sel_sts) rdata = {20'h0, lane_q, 1'b0, sts_tmo, flg_q, done_q, busy};
        else if (idx_ok) begin
            if (sel_opa)      rdata = opa_q[lidx];
            else if (sel_opb) rdata = opb_q[lidx];
            else if (sel_opc) rdata = opc_q[lidx];
            else if (sel_out) rdata = out_q[lidx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            lane_q  <= 4'd0;
            cmd_q   <= 32'h0;
            done_q  <= 1'b0;
            flg_q   <= 4'd0;
            rst_q   <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            cmd_q   <= cmd_d;
            done_q  <= done_d;
            flg_q   <= flg_d;
            rst_q   <= soft_rst;
            if (rd) dout_q <= rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                opa_q[i] <= 32'h0;
                opb_q[i] <= 32'h0;
                opc_q[i] <= 32'h0;
                out_q[i] <= 32'h0;
            end
        end else begin
            if (bank_we && sel_opa) opa_q[lidx] <= sw_datain;
            if (bank_we && sel_opb) opb_q[lidx] <= sw_datain;
            if (bank_we && sel_opc) opc_q[lidx] <= sw_datain;
            if (capture)            out_q[cur]  <= fpu_result;
        end
    end

    assign sw_dataout    = dout_q;
    assign fpu_rst       = rst_q;
    assign fpu_en        = cmd_q[1];
    assign fpu_format    = cmd_q[6:5];
    assign fpu_operation = cmd_q[12:11];
    assign fpu_fused_m_a = cmd_q[11] & cmd_q[12];
    assign fpu_operand_a = opa_q[cur];
    assign fpu_operand_b = opb_q[cur];
    assign fpu_operand_c = opc_q[cur];
    assign irq           = cmd_q[3] & done_q;

endmodule

// File: tb/tb_hci_lane_seq.sv
// Directed bench for hci_lane_seq: register vector table plus hand-written job sequences against a small FPU model.
module tb_hci_lane_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] sw_address, sw_datain, sw_dataout;
    logic        sw_read_en, sw_write_en;
    logic        fpu_rst, fpu_en, fpu_start, fpu_fused_m_a, fpu_ready, irq;
    logic [31:0] fpu_operand_a, fpu_operand_b, fpu_operand_c, fpu_result;
    logic [1:0]  fpu_format, fpu_operation;
    logic [3:0]  fpu_flags;

    hci_lane_seq #(.NUM_LANES(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .sw_address(sw_address), .sw_read_en(sw_read_en), .sw_write_en(sw_write_en),
        .sw_datain(sw_datain), .sw_dataout(sw_dataout),
        .fpu_rst(fpu_rst), .fpu_en(fpu_en), .fpu_start(fpu_start),
        .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b), .fpu_operand_c(fpu_operand_c),
        .fpu_format(fpu_format), .fpu_operation(fpu_operation), .fpu_fused_m_a(fpu_fused_m_a),
        .fpu_result(fpu_result), .fpu_flags(fpu_flags), .fpu_ready(fpu_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Start/reset recorder, sampled mid-cycle.
    int          n_starts = 0;
    int          n_rst    = 0;
    int          st_cyc [64];
    logic [31:0] st_opa [64];
    always @(negedge clk) begin
        if (fpu_start) begin
            st_cyc[n_starts & 63] = cyc;
            st_opa[n_starts & 63] = fpu_operand_a;
            n_starts++;
        end
        if (fpu_rst) n_rst++;
    end

    // FPU model: ready pulse 4 cycles after the start cycle, result = res_base + lane, lane 2 flags overflow.
    logic        model_en = 1'b1;
    logic [31:0] res_base = 32'h100;
    int          mcnt     = 0;
    int          job_mark = 0;
    initial begin
        fpu_ready  = 1'b0;
        fpu_result = 32'h0;
        fpu_flags  = 4'h0;
        forever begin
            @(negedge clk);
            if (fpu_start && model_en) begin
                int lane_v;
                lane_v = mcnt - job_mark;
                mcnt++;
                repeat (4) @(posedge clk);
                #1;
                fpu_result = res_base + 32'(lane_v);
                fpu_flags  = (lane_v == 2) ? 4'h2 : 4'h0;
                fpu_ready  = 1'b1;
                @(posedge clk);
                #1;
                fpu_ready = 1'b0;
                fpu_flags = 4'h0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sw_address  = a;
        sw_datain   = d;
        sw_write_en = 1'b1;
        @(posedge clk);
        #1;
        sw_write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sw_address = a;
        sw_read_en = 1'b1;
        @(posedge clk);
        #1;
        sw_read_en = 1'b0;
        d = sw_dataout;
    endtask

    task automatic wait_irq(input int limit, output int at_cyc);
        at_cyc = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (irq) begin
                at_cyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [32];
    int   nv = 0;

    task automatic add_vec(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
        vecs[nv] = '{wr: w, addr: a, data: d, exp: e};
        nv++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        int          at, b, r, w;

        reset_n = 1'b0;
        sw_address = 32'h0; sw_datain = 32'h0; sw_read_en = 1'b0; sw_write_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dataout", sw_dataout, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_start", {31'h0, fpu_start}, 32'h0);
        chk("rst_fpu_rst", {31'h0, fpu_rst}, 32'h0);
        chk("rst_operand_a", fpu_operand_a, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        add_vec(0, 32'h000, 32'h0, 32'h0);
        add_vec(0, 32'h110, 32'h0, 32'h0);
        add_vec(0, 32'h130, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            add_vec(1, 32'h010 + 32'(4 * i), 32'hA000_0000 + 32'(i), 32'h0);
            add_vec(1, 32'h050 + 32'(4 * i), 32'hB000_0000 + 32'(i), 32'h0);
            add_vec(1, 32'h090 + 32'(4 * i), 32'hC000_0000 + 32'(i), 32'h0);
        end
        add_vec(0, 32'h010, 32'h0, 32'hA000_0000);
        add_vec(0, 32'h05C, 32'h0, 32'hB000_0003);
        add_vec(0, 32'h098, 32'h0, 32'hC000_0002);
        add_vec(1, 32'h020, 32'h0000_FFFF, 32'h0);
        add_vec(0, 32'h020, 32'h0, 32'h0);
        add_vec(0, 32'h0CC, 32'h0, 32'h0);
        add_vec(0, 32'h200, 32'h0, 32'h0);
        add_vec(1, 32'h130, 32'h0000_0055, 32'h0);
        add_vec(0, 32'h130, 32'h0, 32'h0);
        add_vec(1, 32'h000, 32'hABCF_186C, 32'h0);
        add_vec(0, 32'h000, 32'h0, 32'hABC3_1868);
        add_vec(0, 32'h110, 32'h0, 32'h0);

        for (int i = 0; i < nv; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else begin
                bus_read(vecs[i].addr, rv);
                chk($sformatf("vec%0d_rd_%03h", i, vecs[i].addr), rv, vecs[i].exp);
            end
        end
        chk("cmd_format", {30'h0, fpu_format}, 32'h3);
        chk("cmd_operation", {30'h0, fpu_operation}, 32'h3);
        chk("cmd_fused", {31'h0, fpu_fused_m_a}, 32'h1);
        chk("cmd_en", {31'h0, fpu_en}, 32'h0);
        chk("disabled_doorbell_starts", 32'(n_starts), 32'h0);
        bus_write(32'h000, 32'h0);

        // Four-lane job
        job_mark = mcnt; res_base = 32'h100; b = n_starts; w = cyc;
        bus_write(32'h000, 32'h0003_000E);
        wait_irq(100, at);
        chk("job1_irq_seen", {31'h0, at >= 0}, 32'h1);
        chk("job1_starts", 32'(n_starts - b), 32'd4);
        chk("job1_doorbell_to_start", 32'(st_cyc[b & 63] - w), 32'd1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("job1_opa_lane%0d", k), st_opa[(b + k) & 63], 32'hA000_0000 + 32'(k));
        for (int k = 0; k < 3; k++)
            chk($sformatf("job1_spacing%0d", k), 32'(st_cyc[(b + k + 1) & 63] - st_cyc[(b + k) & 63]), 32'd5);
        chk("job1_done_latency", 32'(at - st_cyc[(b + 3) & 63]), 32'd5);
        for (int k = 0; k < 4; k++) begin
            bus_read(32'h130 + 32'(4 * k), rv);
            chk($sformatf("job1_out%0d", k), rv, 32'h100 + 32'(k));
        end
        bus_read(32'h110, rv);
        chk("job1_status", rv, 32'h0000_000A);
        chk("job1_irq", {31'h0, irq}, 32'h1);

        // W1C behaviour
        bus_write(32'h110, 32'h2);
        chk("w1c_irq_drop", {31'h0, irq}, 32'h0);
        bus_read(32'h110, rv);
        chk("w1c_flags_kept", rv, 32'h0000_0008);
        bus_write(32'h110, 32'h3C);
        bus_read(32'h110, rv);
        chk("w1c_all_clear", rv, 32'h0);

        // Busy protection
        job_mark = mcnt; b = n_starts;
        bus_write(32'h000, 32'h0003_000E);
        @(posedge clk);
        #1;
        bus_write(32'h010, 32'h0000_DEAD);
        bus_write(32'h000, 32'h0003_000E);
        wait_irq(100, at);
        chk("job2_irq_seen", {31'h0, at >= 0}, 32'h1);
        repeat (10) @(posedge clk);
        #1;
        chk("job2_starts", 32'(n_starts - b), 32'd4);
        bus_read(32'h010, rv);
        chk("job2_opa0_protected", rv, 32'hA000_0000);
        bus_read(32'h110, rv);
        chk("job2_status", rv, 32'h0000_000A);
        bus_write(32'h110, 32'h7E);

        // Soft reset during WAIT of lane 1
        job_mark = mcnt; res_base = 32'h200; b = n_starts; r = n_rst;
        bus_write(32'h000, 32'h0003_000E);
        repeat (6) @(posedge clk);
        #1;
        bus_write(32'h000, 32'h0003_000B);
        chk("srst_pulse_hi", {31'h0, fpu_rst}, 32'h1);
        @(posedge clk);
        #1;
        chk("srst_pulse_lo", {31'h0, fpu_rst}, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        chk("srst_pulse_count", 32'(n_rst - r), 32'd1);
        chk("srst_starts", 32'(n_starts - b), 32'd2);
        bus_read(32'h110, rv);
        chk("srst_status", rv, 32'h0);
        chk("srst_irq", {31'h0, irq}, 32'h0);
        bus_read(32'h130, rv);
        chk("srst_out0", rv, 32'h200);
        bus_read(32'h134, rv);
        chk("srst_out1_late_ready_ignored", rv, 32'h101);
        bus_read(32'h000, rv);
        chk("srst_cmd", rv, 32'h0003_000A);

        // FPU never answers
        model_en = 1'b0; b = n_starts;
        bus_write(32'h000, 32'h0003_000E);
        repeat (20) @(posedge clk);
        #1;
        chk("hang_starts", 32'(n_starts - b), 32'd1);
        bus_read(32'h110, rv);
`ifdef HCI_TIMEOUT_EN
        chk("tmo_status", rv, 32'h0000_0042);
        chk("tmo_irq", {31'h0, irq}, 32'h1);
`else
        chk("hang_status_busy", rv, 32'h0000_0001);
        chk("hang_irq", {31'h0, irq}, 32'h0);
        bus_write(32'h000, 32'h0003_000B);
        bus_read(32'h110, rv);
        chk("hang_recover_status", rv, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hci_lane_seq.md
# hci_lane_seq

Parametrised successor to the single-lane FPU host control interface. It holds a command register, a status register, and per-lane A/B/C operand and result banks for NUM_LANES lanes, all mapped into the software address space. A doorbell starts a hardware sequencer that issues the active lanes to the FPU one at a time, gathers the results and sticky exception flags, and then raises a maskable interrupt. It sits between the software bus and the FPU datapath.

## Interface
- NUM_LANES, 4, number of operand/result lanes, 1..16
- TIMEOUT_CYCLES, 1024, per-lane watchdog limit in cycles, 1..65535; used only with HCI_TIMEOUT_EN
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- sw_address  in  32  byte address
- sw_read_en / sw_write_en  in  1  read/write strobe; both high = no-op
- sw_datain  in  32  write data
- sw_dataout  out  32  registered read data
- fpu_rst  out  1  one-cycle FPU reset pulse
- fpu_en  out  1  cmd[1]
- fpu_start  out  1  one-cycle issue strobe
- fpu_operand_a/b/c  out  32  operands of the current lane
- fpu_format  out  2  cmd[6:5]
- fpu_operation  out  2  cmd[12:11]
- fpu_fused_m_a  out  1  cmd[11] & cmd[12]
- fpu_result  in  32  result data
- fpu_flags  in  4  {inexact, underflow, overflow, invalid}
- fpu_ready  in  1  result-valid pulse
- irq  out  1  level interrupt

## Operation
- Map: CMD 0x000; OPA lane i at 0x010+4i; OPB at 0x050+4i; OPC at 0x090+4i; STATUS 0x110; OUT lane i at 0x130+4i (read-only). Lane index ≥ NUM_LANES: write ignored, read returns 0. Unmapped read returns 0.
- CMD: [0] soft reset (write 1, self-clears, reads 0); [1] enable; [2] doorbell (write 1 starts a job, reads as busy); [3] int_en; [6:5] format; [12:11] operation; [19:16] last-lane index, clamped to NUM_LANES-1. Other bits are stored and read back.
- STATUS: [0] busy (RO); [1] done (W1C); [2] invalid, [3] overflow, [4] underflow, [5] inexact (sticky OR over lanes, W1C); [6] timeout (W1C); [11:8] current lane (RO); all other bits 0.
- FSM IDLE→ISSUE→WAIT→(ISSUE | DONE)→IDLE.
  - IDLE: a doorbell write with cmd[1]=1 (in the written data, or already set) clears STATUS[6:1], sets lane=0 and moves to ISSUE. A doorbell with enable=0 is ignored.
  - ISSUE: fpu_start=1 for one cycle with lane operands driven; move to WAIT.
  - WAIT: on fpu_ready, capture OUT[lane]<=fpu_result and OR fpu_flags into the sticky bits. If lane==last, go to DONE; otherwise lane+1 and go to ISSUE.
  - DONE: set done and go to IDLE.
- fpu_ready outside WAIT is ignored.
- Operand, OUT, and CMD[19:3] writes while busy are ignored. Doorbell while busy is ignored.
- Soft reset in any state: fpu_rst pulses high for 1 cycle, FSM goes to IDLE, lane=0, done is not set. Operand/OUT banks are retained.
- A W1C write in the same cycle as a hardware set: set wins.
- irq = int_en & done.

## Timing
- Reset values: all registers 0; sw_dataout=0, fpu_start=0, fpu_rst=0, irq=0, all other outputs 0.
- Reads: data appears on sw_dataout the cycle after the strobe and holds until the next read.
- Doorbell sampled at edge N: fpu_start is high in cycle N+1.
- Per lane: 1 issue cycle + FPU latency + 1 capture edge. The next lane's fpu_start follows the ready edge by exactly one cycle.
- done/irq visible 1 cycle after the last ready edge (DONE state), busy=0 in the same cycle.

## Configuration
- HCI_TIMEOUT_EN defined: a 16-bit counter runs in WAIT and clears in ISSUE. Reaching TIMEOUT_CYCLES sets STATUS[6], aborts the remaining lanes and enters DONE (done and irq still asserted).
- HCI_TIMEOUT_EN undefined: WAIT holds indefinitely, STATUS[6] reads 0, no counter logic is present.

## Test plan
- Reset: after reset_n low, read CMD, STATUS, OUT0 → each reads 0x0; irq=0.
- 4-lane job: write OPA/B/C lanes 0..3, CMD=0x0003000E, FPU model returns lane+0x100 after 3 cycles with lane 2 flags=0x2 → OUT0..3=0x100..0x103, STATUS=0x0000000A then irq=1, exactly 4 fpu_start pulses 5 cycles apart.
- W1C: write STATUS=0x2 → irq drops the next cycle and flags remain. Write 0x3C → STATUS=0x0.
- Busy protection: write OPA0=0xDEAD during WAIT and a second doorbell → OPA0 unchanged, only the original job's pulses occur.
- Soft reset mid-job during WAIT of lane 1 → one fpu_rst pulse, STATUS busy=0, done=0, irq=0, a later late fpu_ready ignored.
- HCI_TIMEOUT_EN, TIMEOUT_CYCLES=8, FPU never ready → STATUS=0x42 after 8 WAIT cycles, irq=1 with int_en.
